// File: rtl/axis_read_ctrl.sv
// -----------------------------------------------------------------------------
// axis_read_ctrl
//
// Sequencer for the AXI read path of a stream channel. Accepts one read-stream
// request (start byte address, length in AXI beats), configures the downstream
// axis_read_data block with the matching stream word count, splits the request
// into AXI read-address bursts throttled by a credit count of beats in flight,
// and pulses done once every beat has returned and the data block is idle.
//
// Optional feature macro: AXIS_READ_CTRL_BOUNDARY_EN
//   defined     : bursts are clipped so that none crosses a 4 KB boundary
//   not defined : burst length is min(remaining, BURST_MAX)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_addr, cfg_length       request: start byte address, length in beats
//   cfg_valid / cfg_ready      request handshake (ready only while idle)
//   axi_araddr, axi_arlen      read-address channel payload (arlen = beats-1)
//   axi_arvalid / axi_arready  read-address handshake
//   axi_rvalid, axi_rready     monitored only; both high = one beat received
//   rd_cfg_length              stream word count for the data block
//   rd_cfg_valid / rd_cfg_ready data-block configuration handshake
//   busy                       high whenever the sequencer is not idle
//   done                       one-cycle completion pulse
// -----------------------------------------------------------------------------
module axis_read_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int CONFIG_DWIDTH  = 32,
    parameter int WIDTH_RATIO    = 16,
    parameter int BURST_MAX      = 16,
    parameter int MAX_INFLIGHT   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]                axi_arlen,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    input  logic                      axi_rvalid,
    input  logic                      axi_rready,
    output logic [CONFIG_DWIDTH-1:0]  rd_cfg_length,
    output logic                      rd_cfg_valid,
    input  logic                      rd_cfg_ready,
    output logic                      busy,
    output logic                      done
);

    localparam int BYTES      = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int INF_W      = $clog2(MAX_INFLIGHT + 1) + 1;
    localparam int BLEN_W     = 9;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        CONFIG = 5'b00010,
        ADDR   = 5'b00100,
        DRAIN  = 5'b01000,
        DONE   = 5'b10000
    } state_t;

    state_t                    state_r;
    logic [AXI_ADDR_WIDTH-1:0] addr_r;
    logic [AXI_ADDR_WIDTH-1:0] araddr_r;
    logic [7:0]                arlen_r;
    logic                      arvalid_r;
    logic [CONFIG_DWIDTH-1:0]  remaining_r;
    logic [CONFIG_DWIDTH-1:0]  rd_cfg_length_r;
    logic [INF_W-1:0]          inflight_r;
    logic [BLEN_W-1:0]         blen_r;

    logic [BLEN_W-1:0]         blen_s;
    logic                      credit_ok_s;
    logic                      ar_hs_s;
    logic                      beat_s;
    logic [INF_W-1:0]          inflight_nxt_s;

    // Smaller of two burst-length candidates.
    function automatic logic [BLEN_W-1:0] min_blen(input logic [BLEN_W-1:0] a,
                                                   input logic [BLEN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Burst length for the next AR from the current address and remaining count.
    always_comb begin
        logic [BLEN_W-1:0] cap_v;
        logic [12:0]       bnd_v;
        cap_v = BLEN_W'(BURST_MAX);
        bnd_v = 13'd0;
        if (remaining_r < CONFIG_DWIDTH'(BURST_MAX)) begin
            cap_v = remaining_r[BLEN_W-1:0];
        end else begin
            cap_v = BLEN_W'(BURST_MAX);
        end
`ifdef AXIS_READ_CTRL_BOUNDARY_EN
        // Beats left before the next 4 KB page; at least 1 for aligned addresses.
        bnd_v = (13'd4096 - {1'b0, addr_r[11:0]}) >> BYTE_SHIFT;
        if (bnd_v < 13'(cap_v)) begin
            blen_s = bnd_v[BLEN_W-1:0];
        end else begin
            blen_s = min_blen(cap_v, cap_v);
        end
`else
        blen_s = min_blen(cap_v, BLEN_W'(BURST_MAX));
`endif
    end

    // Credit check, handshake decode and next in-flight beat count.
    always_comb begin
        credit_ok_s    = ((32'(inflight_r) + 32'(blen_s)) <= 32'(MAX_INFLIGHT));
        ar_hs_s        = arvalid_r & axi_arready;
        beat_s         = axi_rvalid & axi_rready;
        inflight_nxt_s = inflight_r;
        if (state_r == IDLE) begin
            inflight_nxt_s = {INF_W{1'b0}};
        end else begin
            case ({ar_hs_s, beat_s})
                2'b11:   inflight_nxt_s = inflight_r + INF_W'(blen_r) - INF_W'(1);
                2'b10:   inflight_nxt_s = inflight_r + INF_W'(blen_r);
                2'b01: begin
                    // Stray beats with nothing outstanding must not wrap the count.
                    if (inflight_r != {INF_W{1'b0}}) begin
                        inflight_nxt_s = inflight_r - INF_W'(1);
                    end else begin
                        inflight_nxt_s = inflight_r;
                    end
                end
                default: inflight_nxt_s = inflight_r;
            endcase
        end
    end

    // Main sequencer FSM with registered AR channel and data-block config.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            addr_r          <= {AXI_ADDR_WIDTH{1'b0}};
            araddr_r        <= {AXI_ADDR_WIDTH{1'b0}};
            arlen_r         <= 8'd0;
            arvalid_r       <= 1'b0;
            remaining_r     <= {CONFIG_DWIDTH{1'b0}};
            rd_cfg_length_r <= {CONFIG_DWIDTH{1'b0}};
            inflight_r      <= {INF_W{1'b0}};
            blen_r          <= {BLEN_W{1'b0}};
        end else begin
            inflight_r <= inflight_nxt_s;
            case (state_r)
                IDLE: begin
                    if (cfg_valid) begin
                        addr_r          <= cfg_addr;
                        remaining_r     <= cfg_length;
                        rd_cfg_length_r <= cfg_length * CONFIG_DWIDTH'(WIDTH_RATIO);
                        state_r         <= (cfg_length == {CONFIG_DWIDTH{1'b0}}) ? DONE : CONFIG;
                    end
                end
                CONFIG: begin
                    if (rd_cfg_ready) begin
                        state_r <= ADDR;
                        // Issue the first burst straight away so AR follows the
                        // config handshake by one cycle.
                        if (credit_ok_s) begin
                            arvalid_r <= 1'b1;
                            araddr_r  <= addr_r;
                            arlen_r   <= 8'(blen_s - BLEN_W'(1));
                            blen_r    <= blen_s;
                        end
                    end
                end
                ADDR: begin
                    if (arvalid_r) begin
                        // Payload is frozen until accepted; the cycle after the
                        // handshake is spent recomputing blen from new state.
                        if (axi_arready) begin
                            arvalid_r   <= 1'b0;
                            addr_r      <= addr_r + (AXI_ADDR_WIDTH'(blen_r) << BYTE_SHIFT);
                            remaining_r <= remaining_r - CONFIG_DWIDTH'(blen_r);
                            if (remaining_r == CONFIG_DWIDTH'(blen_r)) begin
                                state_r <= DRAIN;
                            end
                        end
                    end else if ((remaining_r != {CONFIG_DWIDTH{1'b0}}) && credit_ok_s) begin
                        arvalid_r <= 1'b1;
                        araddr_r  <= addr_r;
                        arlen_r   <= 8'(blen_s - BLEN_W'(1));
                        blen_r    <= blen_s;
                    end
                end
                DRAIN: begin
                    if ((inflight_r == {INF_W{1'b0}}) && rd_cfg_ready) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Outputs are direct decodes of registered state, so they are glitch-free.
    assign cfg_ready     = (state_r == IDLE);
    assign busy          = (state_r != IDLE);
    assign done          = (state_r == DONE);
    assign rd_cfg_valid  = (state_r == CONFIG);
    assign rd_cfg_length = rd_cfg_length_r;
    assign axi_arvalid   = arvalid_r;
    assign axi_araddr    = araddr_r;
    assign axi_arlen     = arlen_r;

endmodule

// File: tb/tb_axis_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_read_ctrl
//
// Directed self-checking bench for axis_read_ctrl. A cycle task records AR
// handshakes and returns read beats from a pending-beat count, optionally
// limited by a beat budget, so credit throttling can be exercised.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_read_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_length;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic        axi_arvalid;
    logic        axi_arready;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] rd_cfg_length;
    logic        rd_cfg_valid;
    logic        rd_cfg_ready;
    logic        busy;
    logic        done;

    int          n_checks;
    int          n_fail;
    int          pending;
    int          ret_budget;
    int          done_cnt;
    logic [31:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];

    axis_read_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_addr      (cfg_addr),
        .cfg_length    (cfg_length),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .axi_araddr    (axi_araddr),
        .axi_arlen     (axi_arlen),
        .axi_arvalid   (axi_arvalid),
        .axi_arready   (axi_arready),
        .axi_rvalid    (axi_rvalid),
        .axi_rready    (axi_rready),
        .rd_cfg_length (rd_cfg_length),
        .rd_cfg_valid  (rd_cfg_valid),
        .rd_cfg_ready  (rd_cfg_ready),
        .busy          (busy),
        .done          (done)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe handshakes completing at the next edge, advance, drive beats.
    task automatic cycle();
        if (axi_arvalid && axi_arready) begin
            ar_addr_q.push_back(axi_araddr);
            ar_len_q.push_back(axi_arlen);
            pending += int'(axi_arlen) + 1;
        end
        if (axi_rvalid && axi_rready) begin
            pending--;
            ret_budget--;
        end
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        axi_rvalid = (pending > 0) && (ret_budget > 0);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] l);
        cfg_addr   = a;
        cfg_length = l;
        cfg_valid  = 1'b1;
        cycle();
        cfg_valid  = 1'b0;
    endtask

    task automatic clear_log();
        ar_addr_q.delete();
        ar_len_q.delete();
        done_cnt = 0;
    endtask

    // Run until done is seen, then step into IDLE and check the tail.
    task automatic wait_done(input string tag, input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            cycle();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        cycle();
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_ready"}, 64'(cfg_ready), 64'd1);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        pending      = 0;
        ret_budget   = 1000000;
        done_cnt     = 0;
        cfg_addr     = 32'd0;
        cfg_length   = 32'd0;
        cfg_valid    = 1'b0;
        axi_arready  = 1'b1;
        axi_rvalid   = 1'b0;
        axi_rready   = 1'b1;
        rd_cfg_ready = 1'b1;
        rst_n        = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(axi_arvalid), 64'd0);
        check("rst_rd_cfg_valid", 64'(rd_cfg_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // 1: 40 beats from 0x1000, prompt responder.
        clear_log();
        start(32'h1000, 32'd40);
        check("t1_rd_cfg_valid", 64'(rd_cfg_valid), 64'd1);
        check("t1_rd_cfg_length", 64'(rd_cfg_length), 64'd640);
        check("t1_ready_low", 64'(cfg_ready), 64'd0);
        cycle();
        check("t1_first_arvalid", 64'(axi_arvalid), 64'd1);
        wait_done("t1", 400);
        check("t1_ar_count", 64'(ar_addr_q.size()), 64'd3);
        if (ar_addr_q.size() == 3) begin
            check("t1_ar0_addr", 64'(ar_addr_q[0]), 64'h1000);
            check("t1_ar0_len", 64'(ar_len_q[0]), 64'd15);
            check("t1_ar1_addr", 64'(ar_addr_q[1]), 64'h1040);
            check("t1_ar1_len", 64'(ar_len_q[1]), 64'd15);
            check("t1_ar2_addr", 64'(ar_addr_q[2]), 64'h1080);
            check("t1_ar2_len", 64'(ar_len_q[2]), 64'd7);
        end

        // 2: 8 beats just below a 4 KB page boundary.
        clear_log();
        start(32'h1FF0, 32'd8);
        wait_done("t2", 400);
`ifdef AXIS_READ_CTRL_BOUNDARY_EN
        check("t2_ar_count", 64'(ar_addr_q.size()), 64'd2);
        if (ar_addr_q.size() == 2) begin
            check("t2_ar0_addr", 64'(ar_addr_q[0]), 64'h1FF0);
            check("t2_ar0_len", 64'(ar_len_q[0]), 64'd3);
            check("t2_ar1_addr", 64'(ar_addr_q[1]), 64'h2000);
            check("t2_ar1_len", 64'(ar_len_q[1]), 64'd3);
        end
`else
        check("t2_ar_count", 64'(ar_addr_q.size()), 64'd1);
        if (ar_addr_q.size() == 1) begin
            check("t2_ar0_addr", 64'(ar_addr_q[0]), 64'h1FF0);
            check("t2_ar0_len", 64'(ar_len_q[0]), 64'd7);
        end
`endif

        // 3: credit throttling with beats withheld, then 16 released.
        clear_log();
        ret_budget = 0;
        start(32'h0, 32'd64);
        for (int i = 0; i < 20; i++) cycle();
        check("t3_two_bursts", 64'(ar_addr_q.size()), 64'd2);
        check("t3_stalled_arvalid", 64'(axi_arvalid), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        ret_budget = 16;
        for (int i = 0; i < 30; i++) cycle();
        check("t3_third_burst", 64'(ar_addr_q.size()), 64'd3);
        check("t3_stalled_again", 64'(axi_arvalid), 64'd0);
        ret_budget = 1000000;
        wait_done("t3", 400);
        check("t3_ar_count", 64'(ar_addr_q.size()), 64'd4);
        if (ar_addr_q.size() == 4) begin
            check("t3_ar2_addr", 64'(ar_addr_q[2]), 64'h80);
            check("t3_ar3_addr", 64'(ar_addr_q[3]), 64'hC0);
            check("t3_ar3_len", 64'(ar_len_q[3]), 64'd15);
        end

        // 4: zero-length request.
        clear_log();
        start(32'h100, 32'd0);
        check("t4_done_pulse", 64'(done), 64'd1);
        check("t4_no_rd_cfg", 64'(rd_cfg_valid), 64'd0);
        check("t4_no_arvalid", 64'(axi_arvalid), 64'd0);
        cycle();
        check("t4_done_low", 64'(done), 64'd0);
        check("t4_ready_back", 64'(cfg_ready), 64'd1);
        check("t4_ar_count", 64'(ar_addr_q.size()), 64'd0);
        check("t4_done_once", 64'(done_cnt), 64'd1);

        // 5: arready held low for 5 cycles on the first burst.
        clear_log();
        axi_arready = 1'b0;
        start(32'h0, 32'd32);
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 64'(axi_arvalid), 64'd1);
            check("t5_hold_addr", 64'(axi_araddr), 64'h0);
            check("t5_hold_len", 64'(axi_arlen), 64'd15);
            cycle();
        end
        axi_arready = 1'b1;
        cycle();
        check("t5_dead_cycle", 64'(axi_arvalid), 64'd0);
        cycle();
        check("t5_next_valid", 64'(axi_arvalid), 64'd1);
        check("t5_next_addr", 64'(axi_araddr), 64'h40);
        check("t5_next_len", 64'(axi_arlen), 64'd15);
        wait_done("t5", 400);
        check("t5_ar_count", 64'(ar_addr_q.size()), 64'd2);

        // 6: reset mid-ADDR, then a fresh short request.
        clear_log();
        start(32'h0, 32'd64);
        for (int i = 0; i < 4; i++) cycle();
        check("t6_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 64'(cfg_ready), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_arvalid", 64'(axi_arvalid), 64'd0);
        check("t6_rst_araddr", 64'(axi_araddr), 64'h0);
        check("t6_rst_arlen", 64'(axi_arlen), 64'd0);
        check("t6_rst_rd_cfg_len", 64'(rd_cfg_length), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        pending    = 0;
        axi_rvalid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        clear_log();
        start(32'h0, 32'd4);
        wait_done("t6", 400);
        check("t6_ar_count", 64'(ar_addr_q.size()), 64'd1);
        if (ar_addr_q.size() == 1) begin
            check("t6_ar0_addr", 64'(ar_addr_q[0]), 64'h0);
            check("t6_ar0_len", 64'(ar_len_q[0]), 64'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_read_ctrl.md
# axis_read_ctrl

Sequencer for the AXI read path of a stream channel. It accepts one read-stream request (start address, length in AXI beats) and configures the downstream `axis_read_data` block with the matching word count. It splits the request into AXI read-address bursts, throttling issue by a credit count of beats in flight, and reports completion once every beat has returned and the data block is idle again.

## Interface
- `AXI_ADDR_WIDTH`, 32, AXI address width.
- `AXI_DATA_WIDTH`, 32, AXI data width; bytes per beat = `AXI_DATA_WIDTH/8`.
- `CONFIG_DWIDTH`, 32, width of length fields.
- `WIDTH_RATIO`, 16, stream words per AXI beat; must match the data block.
- `BURST_MAX`, 16, maximum beats per burst, 1..256.
- `MAX_INFLIGHT`, 32, maximum beats requested but not yet received; must be ≥ `BURST_MAX`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_addr` in `AXI_ADDR_WIDTH`: start byte address, beat-aligned.
- `cfg_length` in `CONFIG_DWIDTH`: length in AXI beats.
- `cfg_valid` in 1 / `cfg_ready` out 1: request handshake.
- `axi_araddr` out `AXI_ADDR_WIDTH`: burst address.
- `axi_arlen` out 8: beats minus 1.
- `axi_arvalid` out 1 / `axi_arready` in 1: read-address handshake.
- `axi_rvalid` in 1, `axi_rready` in 1: monitored only; a beat is received when both are high.
- `rd_cfg_length` out `CONFIG_DWIDTH`: word count to the data block.
- `rd_cfg_valid` out 1 / `rd_cfg_ready` in 1: data-block configuration handshake.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.

## Operation
- One-hot FSM with states IDLE, CONFIG, ADDR, DRAIN, DONE; reset state is IDLE. `cfg_ready` = IDLE.
- **IDLE**:
  - On `cfg_valid`, latch `addr` and `remaining = cfg_length`.
  - If `cfg_length == 0`, go to DONE; otherwise go to CONFIG.
- **CONFIG**:
  - `rd_cfg_valid` = 1 and `rd_cfg_length = cfg_length*WIDTH_RATIO`, truncated to `CONFIG_DWIDTH`.
  - On `rd_cfg_ready`, go to ADDR.
- **ADDR**:
  - Burst length `blen = min(remaining, BURST_MAX, boundary limit)`.
  - A burst is issued only when `inflight + blen ≤ MAX_INFLIGHT`.
  - On AR handshake: `addr += blen*bytes`, `remaining -= blen`, `inflight += blen`.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN**: go to DONE when `inflight == 0` and `rd_cfg_ready == 1`.
- **DONE**: `done` = 1 for one cycle, then go to IDLE.
- `inflight` decrements by 1 on each received beat; a simultaneous AR handshake and beat apply as `+blen-1`.
- Beats received while the FSM is in IDLE are ignored (`inflight` is held at 0).

## Timing
- Reset values: `cfg_ready` 1; all other outputs 0; `inflight`, `remaining` and `addr` 0.
- Reset asserted mid-operation returns the FSM to IDLE immediately; any outstanding AXI transaction is abandoned.
- `axi_arvalid` is registered. Once high, it and `axi_araddr`/`axi_arlen` stay stable until `axi_arready`.
- One dead cycle follows each AR handshake while the next `blen` is computed, so the maximum issue rate is one burst per 2 cycles.
- First `axi_arvalid` rises 1 cycle after the `rd_cfg` handshake, provided credit is available.
- `rd_cfg_valid` rises 1 cycle after the `cfg` handshake.
- `done` rises 1 cycle after the DRAIN exit condition; for zero length, 1 cycle after the `cfg` handshake.
- `cfg_ready` returns high the cycle after `done`.

## Configuration
- `AXIS_READ_CTRL_BOUNDARY_EN` defined: the boundary limit is `(4096 - addr[11:0])/bytes`, so no burst crosses a 4 KB boundary.
- Not defined: there is no boundary limit; `blen = min(remaining, BURST_MAX)`.

## Test plan
All scenarios use defaults with `AXIS_READ_CTRL_BOUNDARY_EN` defined unless stated.

1. Request `addr=0x1000`, `len=40`, `arready` always high, beats returned promptly:
   - AR sequence (0x1000,15), (0x1040,15), (0x1080,7).
   - `rd_cfg_length=640`.
   - `done` once, `busy` low afterwards.
2. Request `addr=0x1FF0`, `len=8`:
   - With macro: AR (0x1FF0,3), (0x2000,3).
   - Without macro: single AR (0x1FF0,7).
3. Request `len=64`, no beats returned: two 16-beat bursts issue, then `axi_arvalid` stays low. Returning 16 beats issues the third burst.
4. Request `len=0`: no `axi_arvalid`, no `rd_cfg_valid`; `done` pulses 1 cycle after the handshake; `cfg_ready` is high the next cycle.
5. `arready` held low 5 cycles during the first burst: `axi_araddr`/`axi_arlen` are stable throughout, and the next burst follows the handshake by 2 cycles.
6. `rst_n` pulsed low mid-ADDR: all outputs take reset values asynchronously. A subsequent request `addr=0x0`, `len=4` completes normally with AR (0x0,3).
